mem_fifo_ctrl: RTL and testbench
================================

# mem_fifo_ctrl

Synchronous FIFO controller that sits directly upstream of the team's dual-port RAM (8-bit × 128, one-cycle registered read, synchronous reset clears array and read data). It turns a push/pop stream interface into the RAM's write/read address, enable and data strobes, and tracks occupancy and status flags. Consumers see popped data one cycle after the pop is accepted, tagged by `pop_valid`.

## Interface
- `WIDTH`, 8: data width; must match the RAM.
- `DEPTH`, 128: entries; must equal 2**ADD_WIDTH.
- `ADD_WIDTH`, 7: RAM address width.
- `AF_LEVEL`, 120: `almost_full` threshold, 1..DEPTH.
- `AE_LEVEL`, 8: `almost_empty` threshold, 0..DEPTH-1.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: reset, synchronous, active-high; tie to RAM `rst`.
- `push` in 1: write request.
- `push_data` in WIDTH: write data.
- `pop` in 1: read request.
- `pop_data` out WIDTH: popped data, valid when `pop_valid`.
- `pop_valid` out 1: `pop_data` holds the entry popped last cycle.
- `full`, `empty`, `almost_full`, `almost_empty` out 1: status flags.
- `count` out ADD_WIDTH+1: occupancy, 0..DEPTH.
- `overflow`, `underflow` out 1: sticky error flags.
- `mem_wr_en` out 1, `mem_wr_addr` out ADD_WIDTH, `mem_wdata` out WIDTH: to RAM write port.
- `mem_rd_en` out 1, `mem_rd_addr` out ADD_WIDTH: to RAM read port.
- `mem_rdata` in WIDTH: from RAM `rdata`.

## Operation
- Pointers `wptr`, `rptr`: ADD_WIDTH+1 bits; low ADD_WIDTH bits address the RAM, MSB is wrap bit. Increment modulo 2**(ADD_WIDTH+1); address wraps DEPTH-1 -> 0.
- Accepted push `wa = push & ~full`; accepted pop `ra = pop & ~empty`; decided from registered flags of the current cycle.
- `mem_wr_en = wa`, `mem_wr_addr = wptr[ADD_WIDTH-1:0]`, `mem_wdata = push_data`; `mem_rd_en = ra`, `mem_rd_addr = rptr[ADD_WIDTH-1:0]`. All combinational; forced 0 while `rst`.
- `pop_data = mem_rdata` (pass-through); `pop_valid` register <= `ra`.
- `count` next = count + wa − ra; both accepted -> unchanged.
- Registered from next count: `full` (== DEPTH), `empty` (== 0), `almost_full` (>= AF_LEVEL), `almost_empty` (<= AE_LEVEL).
- Full + push + pop: pop accepted, push rejected (no pass-through). Empty + push + pop: push accepted, pop rejected (no bypass).
- Popped address always holds data written in an earlier cycle; the RAM's same-address write/read ordering is never relied on.
- Reset mid-operation: pointers, count, flags cleared next edge; in-flight `pop_valid` dropped; contents discarded.

## Timing
- Reset values: `count`=0, `empty`=1, `almost_empty`=1, `full`=0, `almost_full`=0, `pop_valid`=0, `overflow`=0, `underflow`=0; `pop_data` = 0 (RAM reset).
- Push in cycle N -> `count`/flags updated at N+1; entry poppable from N+1.
- Pop accepted in cycle N -> `pop_valid`=1 and `pop_data` valid in N+1 only.
- Back-to-back pops sustain one entry per cycle; throughput one push and one pop per cycle.

## Configuration
- `FIFO_CTRL_ERR_EN` defined: `overflow` sets on `push & full`, `underflow` sets on `pop & empty`; both sticky until `rst`.
- Not defined: error logic absent; `overflow`, `underflow` tied 0. Ports kept in both builds.

## Test plan
- Reset then idle -> `empty`=1, `almost_empty`=1, `count`=0, `pop_valid`=0, no `mem_*_en`.
- Push 0x01..0x80 (128 cycles) -> `almost_full` rises when count reaches 120, `full`=1 at count 128; 129th push -> `mem_wr_en`=0, `overflow`=1 (ERR_EN).
- Pop 128 back-to-back after fill -> `pop_data` 0x01..0x80 in order, each one cycle after accept; `empty`=1 after last; extra pop -> `mem_rd_en`=0, `underflow`=1.
- Full FIFO, push 0xAA + pop same cycle -> pop accepted, push dropped, `count` 128->127, `full`=0.
- Count 5, simultaneous push/pop for 300 cycles -> `count` stays 5, pointers wrap past 127, data order preserved.
- Assert `rst` with count 40 and a pop in flight -> next cycle `count`=0, `empty`=1, `pop_valid`=0, error flags cleared.

Source files
------------

// File: rtl/mem_fifo_ctrl.sv
// mem_fifo_ctrl: push/pop FIFO controller driving an external dual-port RAM
// (one-cycle registered read). Tracks occupancy and status flags.
// Optional sticky error flags are built when FIFO_CTRL_ERR_EN is defined;
// otherwise overflow/underflow are tied low but the ports remain.
module mem_fifo_ctrl #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 128,
  parameter int unsigned ADD_WIDTH = 7,
  parameter int unsigned AF_LEVEL  = 120,
  parameter int unsigned AE_LEVEL  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic                 pop,
  output logic [WIDTH-1:0]     pop_data,
  output logic                 pop_valid,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ADD_WIDTH:0]   count,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 mem_wr_en,
  output logic [ADD_WIDTH-1:0] mem_wr_addr,
  output logic [WIDTH-1:0]     mem_wdata,
  output logic                 mem_rd_en,
  output logic [ADD_WIDTH-1:0] mem_rd_addr,
  input  logic [WIDTH-1:0]     mem_rdata
);

  localparam int unsigned PW = ADD_WIDTH + 1;

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW-1:0] count_next;
  logic          wa;
  logic          ra;

  // Accept decisions from the registered flags; nothing is accepted in reset
  always_comb begin
    wa         = push & ~full & ~rst;
    ra         = pop & ~empty & ~rst;
    count_next = count + PW'(wa) - PW'(ra);
  end

  // RAM strobes; address/data held at zero while in reset
  always_comb begin
    mem_wr_en   = wa;
    mem_rd_en   = ra;
    mem_wr_addr = rst ? '0 : wptr[ADD_WIDTH-1:0];
    mem_rd_addr = rst ? '0 : rptr[ADD_WIDTH-1:0];
    mem_wdata   = rst ? '0 : push_data;
  end

  // Read data comes straight from the RAM's registered output
  assign pop_data = mem_rdata;

  // Pointers, occupancy, status flags and the pop-valid tag
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      pop_valid    <= 1'b0;
    end else begin
      if (wa) wptr <= wptr + PW'(1);
      if (ra) rptr <= rptr + PW'(1);
      count        <= count_next;
      full         <= (count_next == PW'(DEPTH));
      empty        <= (count_next == '0);
      almost_full  <= (count_next >= PW'(AF_LEVEL));
      almost_empty <= (count_next <= PW'(AE_LEVEL));
      pop_valid    <= ra;
    end
  end

`ifdef FIFO_CTRL_ERR_EN
  // Sticky error flags: a request against a full/empty FIFO, held until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push & full)  overflow  <= 1'b1;
      if (pop & empty)  underflow <= 1'b1;
    end
  end
`else
  // Error logic not built
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Bench for mem_fifo_ctrl: includes a behavioural model of the dual-port RAM
// and checks the controller against a queue-based FIFO reference model.
// Honours FIFO_CTRL_ERR_EN for the expected error-flag behaviour.
module tb_mem_fifo_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 128;
  localparam int unsigned AW    = 7;
  localparam int unsigned AF    = 120;
  localparam int unsigned AE    = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             push;
  logic [WIDTH-1:0] push_data;
  logic             pop;
  logic [WIDTH-1:0] pop_data;
  logic             pop_valid;
  logic             full, empty, almost_full, almost_empty;
  logic [AW:0]      count;
  logic             overflow, underflow;
  logic             mem_wr_en;
  logic [AW-1:0]    mem_wr_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_rd_en;
  logic [AW-1:0]    mem_rd_addr;
  logic [WIDTH-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_fifo_ctrl #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADD_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
    .pop_data(pop_data), .pop_valid(pop_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .mem_wr_en(mem_wr_en),
    .mem_wr_addr(mem_wr_addr), .mem_wdata(mem_wdata), .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr), .mem_rdata(mem_rdata)
  );

  // Dual-port RAM: registered read, synchronous reset clears array and rdata
  logic [WIDTH-1:0] ram [DEPTH];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) ram[i] <= '0;
      mem_rdata <= '0;
    end else begin
      if (mem_wr_en) ram[mem_wr_addr] <= mem_wdata;
      if (mem_rd_en) mem_rdata <= ram[mem_rd_addr];
    end
  end

  // Reference model state
  logic [WIDTH-1:0] q[$];
  int unsigned      wr_total;
  int unsigned      rd_total;
  bit               exp_pv;
  logic [WIDTH-1:0] exp_data;
  bit               exp_ovf;
  bit               exp_unf;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, check RAM strobes, advance model, check registered outputs
  task automatic step(input bit p, input bit pp, input logic [WIDTH-1:0] d, input bit r);
    bit wa_exp;
    bit ra_exp;
    int unsigned n;
    @(negedge clk);
    push = p; pop = pp; push_data = d; rst = r;
    #1;
    wa_exp = !r && p  && (q.size() < DEPTH);
    ra_exp = !r && pp && (q.size() > 0);
    check_eq("mem_wr_en", 32'(mem_wr_en), 32'(wa_exp));
    check_eq("mem_rd_en", 32'(mem_rd_en), 32'(ra_exp));
    if (wa_exp) begin
      check_eq("mem_wr_addr", 32'(mem_wr_addr), wr_total % DEPTH);
      check_eq("mem_wdata", 32'(mem_wdata), 32'(d));
    end
    if (ra_exp) check_eq("mem_rd_addr", 32'(mem_rd_addr), rd_total % DEPTH);
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      wr_total = 0; rd_total = 0;
      exp_pv = 0; exp_ovf = 0; exp_unf = 0;
    end else begin
`ifdef FIFO_CTRL_ERR_EN
      if (p  && q.size() == DEPTH) exp_ovf = 1;
      if (pp && q.size() == 0)     exp_unf = 1;
`endif
      exp_pv = ra_exp;
      if (ra_exp) begin exp_data = q.pop_front(); rd_total++; end
      if (wa_exp) begin q.push_back(d); wr_total++; end
    end
    n = q.size();
    check_eq("count", 32'(count), n);
    check_eq("full", 32'(full), 32'(n == DEPTH));
    check_eq("empty", 32'(empty), 32'(n == 0));
    check_eq("almost_full", 32'(almost_full), 32'(n >= AF));
    check_eq("almost_empty", 32'(almost_empty), 32'(n <= AE));
    check_eq("pop_valid", 32'(pop_valid), 32'(exp_pv));
    if (exp_pv) check_eq("pop_data", 32'(pop_data), 32'(exp_data));
    if (r) check_eq("pop_data_rst", 32'(pop_data), 32'd0);
    check_eq("overflow", 32'(overflow), 32'(exp_ovf));
    check_eq("underflow", 32'(underflow), 32'(exp_unf));
  endtask

  initial begin
    int bias;
    logic [WIDTH-1:0] v;
    push = 0; pop = 0; push_data = '0; rst = 1;
    wr_total = 0; rd_total = 0; exp_pv = 0; exp_data = '0; exp_ovf = 0; exp_unf = 0;

    // Reset, then idle; push/pop held during reset must not strobe the RAM
    step(1, 1, 8'h55, 1);
    step(0, 0, 8'h00, 1);
    repeat (3) step(0, 0, 8'h00, 0);

    // Fill with 0x01..0x80, then one push too many
    for (int i = 0; i < int'(DEPTH); i++) begin
      v = WIDTH'(i + 1);
      step(1, 0, v, 0);
    end
    step(1, 0, 8'hEE, 0);

    // Drain back-to-back, then one pop too many
    for (int i = 0; i < int'(DEPTH); i++) step(0, 1, 8'h00, 0);
    step(0, 1, 8'h00, 0);
    step(0, 0, 8'h00, 0);

    // Full FIFO with simultaneous push and pop: pop wins, push dropped
    step(0, 0, 8'h00, 1);
    for (int i = 0; i < int'(DEPTH); i++) step(1, 0, 8'($urandom), 0);
    step(1, 1, 8'hAA, 0);
    step(0, 0, 8'h00, 0);

    // Empty FIFO with simultaneous push and pop: push wins, no bypass
    step(0, 0, 8'h00, 1);
    step(1, 1, 8'h3C, 0);
    step(0, 1, 8'h00, 0);

    // Steady state at count 5 across pointer wrap
    step(0, 0, 8'h00, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 8'($urandom), 0);
    for (int i = 0; i < 300; i++) step(1, 1, 8'($urandom), 0);

    // Randomized traffic with varying fill bias and occasional reset
    for (int blk = 0; blk < 20; blk++) begin
      bias = (blk % 3 == 0) ? 85 : ((blk % 3 == 1) ? 15 : 50);
      for (int i = 0; i < 100; i++)
        step(($urandom_range(0, 99) < bias), ($urandom_range(0, 99) < (100 - bias)),
             8'($urandom), ($urandom_range(0, 599) == 0));
    end

    // Reset with count 40 and a pop in flight
    step(0, 0, 8'h00, 1);
    for (int i = 0; i < 40; i++) step(1, 0, 8'($urandom), 0);
    step(1, 1, 8'h00, 0);
    step(1, 1, 8'h00, 1);
    step(0, 0, 8'h00, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
